arbitro_acesso_perfis: RTL

ARBITRO_ACESSO_PERFIS -- requirements
Module: arbitro_acesso_perfis

---
 rtl/arb_perfis_pkg.sv | 22 ++
 rtl/contador_posse.sv | 33 +++
 rtl/arbitro_acesso_perfis.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/arb_perfis_pkg.sv
// Shared types and defaults for the two-profile access arbiter.
package arb_perfis_pkg;

    localparam int FUNC_W_DEF   = 3;
    localparam int MAX_HOLD_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        G0    = 2'd1,
        G1    = 2'd2,
        GBOTH = 2'd3
    } estado_t;

    function automatic logic tem_gnt0(input estado_t s);
        return (s == G0) || (s == GBOTH);
    endfunction

    function automatic logic tem_gnt1(input estado_t s);
        return (s == G1) || (s == GBOTH);
    endfunction

endpackage

// File: rtl/contador_posse.sv
// Grant hold counter: counts granted cycles and flags the last allowed one.
// Only present when ARB_TIMEOUT_EN is defined.
`ifdef ARB_TIMEOUT_EN
module contador_posse #(
    parameter int MAX_HOLD = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic terminal
);

    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX_HOLD - 1);

    logic [CW-1:0] count;

    // Count granted cycles, restart on every release, saturate at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = enable && (count == LAST);

endmodule
`endif

// File: rtl/arbitro_acesso_perfis.sv
// Two-profile access arbiter with function-code conflict detection.
// Optional grant timeout enabled with macro ARB_TIMEOUT_EN.
module arbitro_acesso_perfis
    import arb_perfis_pkg::*;
#(
    parameter int FUNC_W   = FUNC_W_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [FUNC_W-1:0] func0,
    input  logic [FUNC_W-1:0] func1,
    input  logic              done0,
    input  logic              done1,
    input  logic              prio,
    output logic              gnt0,
    output logic              gnt1,
    output logic              conflict,
    output logic              busy
);

    estado_t           state, nxt;
    logic [FUNC_W-1:0] lat0, lat1, lat0_n, lat1_n;
    logic              blk0, blk1, blk0_n, blk1_n;
    logic              set0, set1, conf_n;
    logic              hold0, hold1, rel0, rel1, to0, to1;

    assign hold0 = tem_gnt0(state);
    assign hold1 = tem_gnt1(state);

    // A holder releases on done, on dropping its request, or on timeout
    assign rel0 = hold0 && (done0 || !req0 || to0);
    assign rel1 = hold1 && (done1 || !req1 || to1);

`ifdef ARB_TIMEOUT_EN
    contador_posse #(.MAX_HOLD(MAX_HOLD)) u_cont0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (hold0),
        .clear    (rel0 || !hold0),
        .terminal (to0)
    );

    contador_posse #(.MAX_HOLD(MAX_HOLD)) u_cont1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (hold1),
        .clear    (rel1 || !hold1),
        .terminal (to1)
    );
`else
    logic [31:0] unused_max_hold;
    assign unused_max_hold = 32'(MAX_HOLD);
    assign to0 = 1'b0;
    assign to1 = 1'b0;
`endif

    // Next-state, function latching and conflict/blocked-flag decisions
    always_comb begin
        nxt    = state;
        lat0_n = lat0;
        lat1_n = lat1;
        conf_n = 1'b0;
        set0   = 1'b0;
        set1   = 1'b0;
        blk0_n = blk0 && req0;
        blk1_n = blk1 && req1;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    if (func0 != func1) begin
                        nxt    = GBOTH;
                        lat0_n = func0;
                        lat1_n = func1;
                    end else begin
                        conf_n = 1'b1;
                        if (prio) begin
                            nxt    = G1;
                            lat1_n = func1;
                            set0   = 1'b1;
                        end else begin
                            nxt    = G0;
                            lat0_n = func0;
                            set1   = 1'b1;
                        end
                    end
                end else if (req0) begin
                    nxt    = G0;
                    lat0_n = func0;
                end else if (req1) begin
                    nxt    = G1;
                    lat1_n = func1;
                end
            end
            G0: begin
                if (rel0) begin
                    conf_n = to0;
                    if (req1) begin
                        nxt    = G1;
                        lat1_n = func1;
                    end else begin
                        nxt = IDLE;
                    end
                end else if (req1) begin
                    if (func1 != lat0) begin
                        nxt    = GBOTH;
                        lat1_n = func1;
                    end else begin
                        conf_n = !blk1;
                        set1   = 1'b1;
                    end
                end
            end
            G1: begin
                if (rel1) begin
                    conf_n = to1;
                    if (req0) begin
                        nxt    = G0;
                        lat0_n = func0;
                    end else begin
                        nxt = IDLE;
                    end
                end else if (req0) begin
                    if (func0 != lat1) begin
                        nxt    = GBOTH;
                        lat0_n = func0;
                    end else begin
                        conf_n = !blk0;
                        set0   = 1'b1;
                    end
                end
            end
            GBOTH: begin
                conf_n = to0 || to1;
                if (rel0 && rel1) begin
                    nxt = IDLE;
                end else if (rel0) begin
                    nxt = G1;
                end else if (rel1) begin
                    nxt = G0;
                end
            end
            default: nxt = IDLE;
        endcase
        if (nxt != state) begin
            blk0_n = 1'b0;
            blk1_n = 1'b0;
        end
        blk0_n = blk0_n || set0;
        blk1_n = blk1_n || set1;
    end

    // State, latched functions and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lat0     <= '0;
            lat1     <= '0;
            blk0     <= 1'b0;
            blk1     <= 1'b0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            conflict <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= nxt;
            lat0     <= lat0_n;
            lat1     <= lat1_n;
            blk0     <= blk0_n;
            blk1     <= blk1_n;
            gnt0     <= tem_gnt0(nxt);
            gnt1     <= tem_gnt1(nxt);
            conflict <= conf_n;
            busy     <= (nxt != IDLE);
        end
    end

endmodule
